alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, multi-cycle successor of the 16-bit core ALU, with a valid/ready handshake.
//  Logic, add/sub and shift ops complete in 1 cycle; MUL/DIV run iteratively over WIDTH cycles.
//  Gives full-width results (product high half / remainder) and variable shift amounts.
//  Sits between the decode/issue stage and writeback; one operation in flight at a time.
// PARAMETERS
//  WIDTH  16  operand/result width; power of 2, >=4
//  OPW    5   opcode width; encodings come from shared defines
//  SHW    $clog2(WIDTH) (localparam)  shift-amount width, taken from b[SHW-1:0]
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operation request
//  in_ready   out  1      high only in IDLE; accept = in_valid & in_ready
//  op         in   OPW    opcode (OP_*), latched on accept
//  a, b       in   WIDTH  operands, latched on accept; may change freely afterwards
//  out_valid  out  1      result/flags valid; held until out_ready
//  out_ready  in   1      consumer takes result; out_valid & out_ready completes op
//  result     out  WIDTH  primary result (sum, diff, logic, shift, product lo, quotient)
//  result_hi  out  WIDTH  product hi (MUL) / remainder (DIV); 0 for all other ops
//  nzcv       out  4      {N,Z,C,V}
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, result_hi=0, nzcv=0; in_ready=1.
//  FSM: IDLE -accept, 1-cycle op-> DONE; IDLE -accept, MUL/DIV-> BUSY; BUSY -count==WIDTH-1-> DONE;
//   DONE -out_ready-> IDLE. in_ready=0 in BUSY and DONE; in_valid is ignored there.
//  Latency (accept edge to out_valid): 1 cycle single-cycle ops; WIDTH+1 cycles MUL/DIV.
//  Outputs registered; result/result_hi/nzcv stable while out_valid=1 and out_ready=0.
//  Flag rules: N=result[WIDTH-1], Z=(result==0), always.
//   ADD: C=carry out, V=signed overflow.
//   SUB/CMP: result=a-b, C=1 iff no borrow (a>=b unsigned), V=signed overflow.
//   CMP is identical to SUB at this block; writeback suppression happens downstream.
//   AND/NAND/OR/NOR/XOR/XNOR: C=0, V=0.
//   SHL/SHR/ASR/ROL/ROR: amount s=b[SHW-1:0]; C=last bit shifted/rotated out; V=0.
//    s=0 -> result=a, C=0. ROL/ROR are modulo WIDTH. ASR replicates a[WIDTH-1].
//   MUL (unsigned, shift-add, 1 bit/cycle): {result_hi,result}=a*b; C=V=(result_hi!=0).
//   DIV (unsigned, restoring, 1 bit/cycle): result=a/b, result_hi=a%b, C=0, V=0.
//    b==0: result=all ones, result_hi=a, V=1; still takes the full WIDTH+1 cycles.
//  Undefined opcode: completes in 1 cycle, result=0, result_hi=0, nzcv=4'b0100.
//  Reset asserted mid-BUSY/DONE: operation is discarded, no out_valid pulse follows.
//  No combinational path from in_* to out_*, or from out_ready to in_ready.
// STRUCTURE
//  defines.v (shared): OP_ADD..OP_ASR encodings (incl. OP_CMP, OP_MUL, OP_DIV),
//   flag bit indices NZCV_N=3, NZCV_Z=2, NZCV_C=1, NZCV_V=0, FSM state encodings.
//  Sub-module alu_muldiv_seq: iterative mul/div datapath (acc, quotient/multiplier shift
//   register, bit counter), with start/done handshake to the top FSM; instantiated once.
//  Top: FSM, operand latches, single-cycle datapath, flag generation, output registers.
// TESTING (WIDTH=16)
//  ADD 0x7FFF+0x0001 -> result 0x8000, nzcv 1001, out_valid 1 cycle after accept.
//  SUB 0x0003-0x0005 -> 0xFFFE, nzcv 1000; CMP 0x1234,0x1234 -> 0x0000, nzcv 0110.
//  MUL 0x1234*0x0100 -> result 0x3400, result_hi 0x0012, nzcv 0011;
//   out_valid exactly 17 cycles after accept; in_ready=0 throughout.
//  DIV 100/7 -> result 14, result_hi 2, nzcv 0000;
//   DIV 0x00AB/0 -> result 0xFFFF, result_hi 0x00AB, nzcv 1001.
//  ROL 0x8001 by 4 -> 0x0018, C=0; SHR 0x0003 by 1 -> 0x0001, C=1;
//   ASR 0x8000 by 15 -> 0xFFFF, nzcv 1000; SHL by 0 -> result=a, C=0.
//  Hold out_ready=0 for 5 cycles -> outputs stable, in_valid ignored;
//   rst_n pulse mid-MUL -> all outputs 0, IDLE, next ADD correct.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, flag indices and FSM states
// for the sequential ALU and its mul/div datapath.
package alu_seq_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_CMP  = 2;
  localparam int OP_AND  = 3;
  localparam int OP_NAND = 4;
  localparam int OP_OR   = 5;
  localparam int OP_NOR  = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_XNOR = 8;
  localparam int OP_SHL  = 9;
  localparam int OP_SHR  = 10;
  localparam int OP_ROL  = 11;
  localparam int OP_ROR  = 12;
  localparam int OP_MUL  = 13;
  localparam int OP_DIV  = 14;
  localparam int OP_ASR  = 15;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] pack_nzcv(
    input logic n,
    input logic z,
    input logic c,
    input logic v
  );
    logic [3:0] f;
    f         = '0;
    f[NZCV_N] = n;
    f[NZCV_Z] = z;
    f[NZCV_C] = c;
    f[NZCV_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide
// (restoring), one result bit per cycle.
module alu_muldiv_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic             r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_opd;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_mul_mq;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_div_acc;
  logic [WIDTH-1:0] w_div_mq;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mq_nxt;

  // {acc,mq} shifts right as a 2W product register
  assign w_sum     = {1'b0, r_acc} + {1'b0, r_opd};
  assign w_madd    = r_mq[0] ? w_sum : {1'b0, r_acc};
  assign w_mul_acc = w_madd[WIDTH:1];
  assign w_mul_mq  = {w_madd[0], r_mq[WIDTH-1:1]};

  // remainder in acc, dividend shifts out of mq while quotient shifts in
  assign w_rsh = {r_acc, r_mq[WIDTH-1]};
  assign w_dif = w_rsh - {1'b0, r_opd};

  always_comb begin
    w_div_acc = w_rsh[WIDTH-1:0];
    w_div_mq  = {r_mq[WIDTH-2:0], 1'b0};
    if (!w_dif[WIDTH]) begin
      w_div_acc = w_dif[WIDTH-1:0];
      w_div_mq  = {r_mq[WIDTH-2:0], 1'b1};
    end
  end

  assign w_acc_nxt = r_div ? w_div_acc : w_mul_acc;
  assign w_mq_nxt  = r_div ? w_div_mq : w_mul_mq;

  assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_lo   = w_mq_nxt;
  assign o_hi   = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_mq   <= '0;
      r_opd  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_div  <= i_div;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_mq   <= i_a;
      r_opd  <= i_b;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_mq  <= w_mq_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle
// logic/arith/shift ops plus iterative MUL/DIV.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       nzcv
);

  localparam int SHW = $clog2(WIDTH);

  state_t r_state;
  state_t w_nxt;

  logic r_div_op;
  logic r_divz;

  logic w_accept;
  logic w_md_start;
  logic w_md_done;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_hi;
  logic w_md_nz;
  logic [3:0] w_md_flags;

  logic w_is_add, w_is_sub, w_is_and, w_is_nand;
  logic w_is_or, w_is_nor, w_is_xor, w_is_xnor;
  logic w_is_shl, w_is_shr, w_is_asr, w_is_rol;
  logic w_is_ror, w_is_mul, w_is_div;

  logic [SHW-1:0]    w_s;
  logic [WIDTH:0]    w_add_x;
  logic [WIDTH:0]    w_sub_x;
  logic [WIDTH:0]    w_shl_x;
  logic [WIDTH:0]    w_shr_x;
  logic signed [WIDTH:0] w_asr_x;
  logic [WIDTH-1:0]  w_rol;
  logic [WIDTH-1:0]  w_ror;
  logic [WIDTH-1:0]  w_res;
  logic              w_c;
  logic              w_v;
  logic [3:0]        w_flags;

  assign w_is_add  = op == OPW'(OP_ADD);
  assign w_is_sub  = (op == OPW'(OP_SUB)) || (op == OPW'(OP_CMP));
  assign w_is_and  = op == OPW'(OP_AND);
  assign w_is_nand = op == OPW'(OP_NAND);
  assign w_is_or   = op == OPW'(OP_OR);
  assign w_is_nor  = op == OPW'(OP_NOR);
  assign w_is_xor  = op == OPW'(OP_XOR);
  assign w_is_xnor = op == OPW'(OP_XNOR);
  assign w_is_shl  = op == OPW'(OP_SHL);
  assign w_is_shr  = op == OPW'(OP_SHR);
  assign w_is_asr  = op == OPW'(OP_ASR);
  assign w_is_rol  = op == OPW'(OP_ROL);
  assign w_is_ror  = op == OPW'(OP_ROR);
  assign w_is_mul  = op == OPW'(OP_MUL);
  assign w_is_div  = op == OPW'(OP_DIV);

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_md_start = w_accept && (w_is_mul || w_is_div);

  // carry of a-b computed as a+~b+1, so C=1 means no borrow
  assign w_s     = b[SHW-1:0];
  assign w_add_x = {1'b0, a} + {1'b0, b};
  assign w_sub_x = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign w_shl_x = {1'b0, a} << w_s;
  assign w_shr_x = {a, 1'b0} >> w_s;
  assign w_asr_x = $signed({a, 1'b0}) >>> w_s;

  always_comb begin
    w_rol = '0;
    w_ror = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_rol[i] = a[SHW'(i) - w_s];
      w_ror[i] = a[SHW'(i) + w_s];
    end
  end

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (1'b1)
      w_is_add: begin
        w_res = w_add_x[WIDTH-1:0];
        w_c   = w_add_x[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      w_is_sub: begin
        w_res = w_sub_x[WIDTH-1:0];
        w_c   = w_sub_x[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      w_is_and:  w_res = a & b;
      w_is_nand: w_res = ~(a & b);
      w_is_or:   w_res = a | b;
      w_is_nor:  w_res = ~(a | b);
      w_is_xor:  w_res = a ^ b;
      w_is_xnor: w_res = ~(a ^ b);
      w_is_shl: begin
        w_res = w_shl_x[WIDTH-1:0];
        w_c   = w_shl_x[WIDTH];
      end
      w_is_shr: begin
        w_res = w_shr_x[WIDTH:1];
        w_c   = w_shr_x[0];
      end
      w_is_asr: begin
        w_res = w_asr_x[WIDTH:1];
        w_c   = w_asr_x[0];
      end
      w_is_rol: begin
        w_res = w_rol;
        w_c   = (w_s != '0) && w_rol[0];
      end
      w_is_ror: begin
        w_res = w_ror;
        w_c   = (w_s != '0) && w_ror[WIDTH-1];
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  assign w_flags = pack_nzcv(w_res[WIDTH-1], w_res == '0, w_c, w_v);

  alu_muldiv_seq #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_md_start),
    .i_div   (w_is_div),
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_md_done),
    .o_lo    (w_md_lo),
    .o_hi    (w_md_hi)
  );

  assign w_md_nz    = (w_md_hi != '0);
  assign w_md_flags = pack_nzcv(
    w_md_lo[WIDTH-1],
    w_md_lo == '0,
    !r_div_op && w_md_nz,
    r_div_op ? r_divz : w_md_nz
  );

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nxt = w_md_start ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (w_md_done) begin
          w_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_nxt = ST_IDLE;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_op  <= 1'b0;
      r_divz    <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      nzcv      <= '0;
    end else if (w_accept) begin
      r_div_op <= w_is_div;
      r_divz   <= (b == '0);
      if (!w_md_start) begin
        result    <= w_res;
        result_hi <= '0;
        nzcv      <= w_flags;
      end
    end else if ((r_state == ST_BUSY) && w_md_done) begin
      result    <= w_md_lo;
      result_hi <= w_md_hi;
      nzcv      <= w_md_flags;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16).
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic [3:0]  nzcv;

  int total = 0;
  int bad = 0;

  alu_seq #(.WIDTH(16), .OPW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .nzcv      (nzcv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int o, input logic [15:0] x,
                       input logic [15:0] y);
    @(negedge clk);
    op = 5'(o);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 5'(OP_XOR);
    a = 16'hDEAD;
    b = 16'hBEEF;
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, {out_valid, in_ready}, 32'h1);
  endtask

  task automatic single(input string tag, input int o,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic [3:0] ef);
    issue(o, x, y);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_hi"}, result_hi, 0);
    chk({tag, "_nzcv"}, nzcv, ef);
    consume(tag);
  endtask

  // latency counts the accept edge as cycle 1
  task automatic multi(input string tag, input int o,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] er, input logic [15:0] eh,
                       input logic [3:0] ef);
    int n;
    int rdy;
    issue(o, x, y);
    n = 1;
    rdy = 0;
    while (!out_valid && n < 40) begin
      if (in_ready !== 1'b0) rdy++;
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n++;
    end
    chk({tag, "_lat"}, n, 17);
    chk({tag, "_rdy"}, rdy, 0);
    chk({tag, "_res"}, result, er);
    chk({tag, "_hi"}, result_hi, eh);
    chk({tag, "_nzcv"}, nzcv, ef);
    consume(tag);
  endtask

  initial begin
    int hb;
    int pulses;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_res", result, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_nzcv", nzcv, 0);
    #10;
    rst_n = 1'b1;

    single("add", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
    single("sub", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000);
    single("cmp", OP_CMP, 16'h1234, 16'h1234, 16'h0000, 4'b0110);
    single("xor", OP_XOR, 16'hFF00, 16'h0FF0, 16'hF0F0, 4'b1000);
    single("rol", OP_ROL, 16'h8001, 16'h0004, 16'h0018, 4'b0000);
    single("ror", OP_ROR, 16'h0001, 16'h0001, 16'h8000, 4'b1010);
    single("shr", OP_SHR, 16'h0003, 16'h0001, 16'h0001, 4'b0010);
    single("asr", OP_ASR, 16'h8000, 16'h000F, 16'hFFFF, 4'b1000);
    single("shl0", OP_SHL, 16'hA5A5, 16'h0010, 16'hA5A5, 4'b1000);
    single("undef", 31, 16'h1111, 16'h2222, 16'h0000, 4'b0100);

    multi("mul", OP_MUL, 16'h1234, 16'h0100,
          16'h3400, 16'h0012, 4'b0011);
    multi("div", OP_DIV, 16'd100, 16'd7,
          16'd14, 16'd2, 4'b0000);
    multi("div0", OP_DIV, 16'h00AB, 16'h0000,
          16'hFFFF, 16'h00AB, 4'b1001);

    issue(OP_AND, 16'hF0F0, 16'h3C3C);
    hb = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op = 5'(OP_ADD);
      a = 16'h0001;
      b = 16'h0001;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          result !== 16'h3030 || result_hi !== 16'h0 ||
          nzcv !== 4'b0000) hb++;
    end
    in_valid = 1'b0;
    chk("hold", hb, 0);
    chk("hold_res", result, 16'h3030);
    consume("hold");

    issue(OP_MUL, 16'hFFFF, 16'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_out", {result, result_hi}, 0);
    chk("mrst_nzcv", nzcv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) pulses++;
    end
    chk("mrst_nopulse", pulses, 0);
    single("add2", OP_ADD, 16'h0001, 16'hFFFF, 16'h0000, 4'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
